// File: rtl/sram_arb_pkg.sv
// Shared ids, request bundle and helpers for the two-master SRAM port arbiter.
package sram_arb_pkg;

    localparam logic ARB_ID_FETCH         = 1'b0;
    localparam logic ARB_ID_DATA          = 1'b1;
    localparam int   ARB_STARVE_LIMIT_DEF = 4;
    localparam int   ARB_ADDR_W           = 32;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  wr;
        logic [3:0]            wstrb;
        logic [31:0]           wdata;
    } arb_req_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } resp_state_e;

    // Width of the policy state register; never narrower than one bit.
    function automatic int arb_pol_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way grant for the SRAM port arbiter.
// SRAM_ARB_RR_EN selects round-robin; otherwise m1 priority with an m0 starvation limit.
module arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF,
    parameter int PW           = arb_pol_w(STARVE_LIMIT)
) (
    input  logic [1:0]    req_i,
    input  logic [PW-1:0] pol_q_i,
    output logic [1:0]    gnt_o,
    output logic [PW-1:0] pol_d_o,
    output logic [PW-1:0] pol_rst_o
);

`ifdef SRAM_ARB_RR_EN
    // pol_q holds last_gnt: nonzero means m1 was granted last.
    logic last_m1;
    assign last_m1   = (pol_q_i != '0);
    assign pol_rst_o = PW'(1);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | last_m1);
        gnt_o[1] = req_i[1] & ~gnt_o[0];
        pol_d_o  = pol_q_i;
        if (gnt_o[0])
            pol_d_o = '0;
        else if (gnt_o[1])
            pol_d_o = PW'(1);
    end
`else
    // pol_q holds starve_cnt; reaching the limit hands the next conflict to m0.
    logic starve_hit;
    assign starve_hit = (pol_q_i == PW'(STARVE_LIMIT));
    assign pol_rst_o  = '0;

    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | starve_hit);
        gnt_o[1] = req_i[1] & ~gnt_o[0];
        pol_d_o  = '0;
        if (req_i[0] && gnt_o[1])
            pol_d_o = pol_q_i + PW'(1);
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch (m0) and load/store (m1), fixed 1-cycle latency.
// Conflict policy chosen by SRAM_ARB_RR_EN inside arb_pick.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [3:0]        m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,
    output logic [31:0]       m1_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int PW = arb_pol_w(STARVE_LIMIT);

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [PW-1:0] pol_q, pol_d, pol_rst;
    resp_state_e   state_q, state_d;
    logic          resp_id_q, resp_id_d;
    arb_req_t      m0_bundle, m1_bundle, sel;

    // Masking requests during reset keeps every grant-derived output low.
    assign req = {m1_req & ~reset, m0_req & ~reset};

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .PW           (PW)
    ) u_pick (
        .req_i     (req),
        .pol_q_i   (pol_q),
        .gnt_o     (gnt),
        .pol_d_o   (pol_d),
        .pol_rst_o (pol_rst)
    );

    assign m0_addr_ok = gnt[0];
    assign m1_addr_ok = gnt[1];

    assign m0_bundle = '{addr: ARB_ADDR_W'(m0_addr), wr: 1'b0, wstrb: 4'h0, wdata: 32'h0};
    assign m1_bundle = '{addr: ARB_ADDR_W'(m1_addr), wr: m1_wr, wstrb: m1_wstrb, wdata: m1_wdata};

    always_comb begin
        sel = '0;
        if (gnt[1])
            sel = m1_bundle;
        else if (gnt[0])
            sel = m0_bundle;
    end

    assign sram_en    = |gnt;
    assign sram_addr  = sel.addr[ADDR_W-1:0];
    assign sram_wdata = sel.wdata;
    assign sram_wen   = sel.wr ? sel.wstrb : 4'h0;

    always_comb begin
        state_d   = (|gnt) ? S_RESP : S_IDLE;
        resp_id_d = gnt[1] ? ARB_ID_DATA : ARB_ID_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            resp_id_q <= ARB_ID_FETCH;
            pol_q     <= pol_rst;
        end else begin
            state_q   <= state_d;
            resp_id_q <= resp_id_d;
            pol_q     <= pol_d;
        end
    end

    // A response still registered when reset rises is suppressed, never returned.
    assign m0_data_ok = ~reset & (state_q == S_RESP) & (resp_id_q == ARB_ID_FETCH);
    assign m1_data_ok = ~reset & (state_q == S_RESP) & (resp_id_q == ARB_ID_DATA);

    assign m0_rdata = sram_rdata;
    assign m1_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-writable 1-cycle SRAM model.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m0_addr_ok, m0_data_ok;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0;
    logic        m1_wr = 1'b0;
    logic [3:0]  m1_wstrb = '0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_addr_ok, m1_data_ok;
    logic [31:0] m1_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_wstrb   (m1_wstrb),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .m1_rdata   (m1_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always @(posedge clk) begin
        if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_wen[b]) mem[sram_addr[11:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            if (sram_wen == 4'h0) sram_rdata <= mem[sram_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m1_set(input logic req, input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] data);
        m1_req   = req;
        m1_wr    = wr;
        m1_wstrb = strb;
        m1_addr  = addr;
        m1_wdata = data;
    endtask

    logic       exp_m1;
    logic [1:0] prev_gnt;

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_en",   {31'b0, sram_en}, 32'h0);
        chk("rst_aok",  {30'b0, m1_addr_ok, m0_addr_ok}, 32'h0);
        chk("rst_dok",  {30'b0, m1_data_ok, m0_data_ok}, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Preload boot word, then write 0x10 and read it back
        m1_set(1'b1, 1'b1, 4'hf, 32'hbfc00000, 32'h12345678);
        @(negedge clk);
        chk("pre_aok", {31'b0, m1_addr_ok}, 32'h1);
        chk("pre_wen", {28'b0, sram_wen}, 32'hf);
        tick();
        m1_set(1'b1, 1'b1, 4'hf, 32'h10, 32'hdeadbeef);
        @(negedge clk);
        chk("wr_wen",   {28'b0, sram_wen}, 32'hf);
        chk("wr_wdata", sram_wdata, 32'hdeadbeef);
        chk("wr_addr",  sram_addr, 32'h10);
        tick();
        m1_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("wr_dok",  {31'b0, m1_data_ok}, 32'h1);
        chk("rd_aok",  {31'b0, m1_addr_ok}, 32'h1);
        chk("rd_wen",  {28'b0, sram_wen}, 32'h0);
        tick();
        m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rd_dok",   {31'b0, m1_data_ok}, 32'h1);
        chk("rd_data",  m1_rdata, 32'hdeadbeef);
        chk("idle_en",  {31'b0, sram_en}, 32'h0);
        chk("idle_adr", sram_addr, 32'h0);

        // Fetch-only access
        tick();
        m0_req  = 1'b1;
        m0_addr = 32'hbfc00000;
        @(negedge clk);
        chk("f_aok",  {31'b0, m0_addr_ok}, 32'h1);
        chk("f_addr", sram_addr, 32'hbfc00000);
        chk("f_wen",  {28'b0, sram_wen}, 32'h0);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("f_dok",   {30'b0, m1_data_ok, m0_data_ok}, 32'h1);
        chk("f_rdata", m0_rdata, 32'h12345678);

        // Partial write over 0x11223344
        tick();
        m1_set(1'b1, 1'b1, 4'hf, 32'h20, 32'h11223344);
        tick();
        m1_set(1'b1, 1'b1, 4'h3, 32'h20, 32'haaaabbbb);
        @(negedge clk);
        chk("pw_wen", {28'b0, sram_wen}, 32'h3);
        tick();
        m1_set(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        tick();
        m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pw_dok",  {31'b0, m1_data_ok}, 32'h1);
        chk("pw_data", m1_rdata, 32'h1122bbbb);

        // Both masters requesting for 12 cycles
        tick();
        m0_req  = 1'b1;
        m0_addr = 32'h100;
        m1_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        prev_gnt = 2'b00;
        for (int i = 0; i < 12; i++) begin
`ifdef SRAM_ARB_RR_EN
            exp_m1 = (i % 2 == 1);
`else
            exp_m1 = !(i == 4 || i == 9);
`endif
            @(negedge clk);
            chk($sformatf("cf_gnt%0d", i), {30'b0, m1_addr_ok, m0_addr_ok},
                exp_m1 ? 32'h2 : 32'h1);
            if (i > 0)
                chk($sformatf("cf_dok%0d", i), {30'b0, m1_data_ok, m0_data_ok},
                    {30'b0, prev_gnt});
            prev_gnt = exp_m1 ? 2'b10 : 2'b01;
            tick();
        end
        m0_req = 1'b0;
        m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("cf_dok_last", {30'b0, m1_data_ok, m0_data_ok}, {30'b0, prev_gnt});

        // Reset in the cycle after an m1 read is accepted
        tick();
        m1_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        chk("rr_aok", {31'b0, m1_addr_ok}, 32'h1);
        tick();
        reset  = 1'b1;
        m0_req = 1'b1;
        m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rr_dok", {30'b0, m1_data_ok, m0_data_ok}, 32'h0);
        chk("rr_aok0", {30'b0, m1_addr_ok, m0_addr_ok}, 32'h0);
        chk("rr_en",  {31'b0, sram_en}, 32'h0);
        tick();
        m1_set(1'b1, 1'b1, 4'hf, 32'h40, 32'h55555555);
        @(negedge clk);
        chk("rr_wen",  {28'b0, sram_wen}, 32'h0);
        chk("rr_aok1", {30'b0, m1_addr_ok, m0_addr_ok}, 32'h0);
        chk("rr_dok1", {30'b0, m1_data_ok, m0_data_ok}, 32'h0);
        tick();
        reset = 1'b0;
        m1_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
`ifdef SRAM_ARB_RR_EN
        chk("cold_gnt", {30'b0, m1_addr_ok, m0_addr_ok}, 32'h1);
`else
        chk("cold_gnt", {30'b0, m1_addr_ok, m0_addr_ok}, 32'h2);
`endif
        chk("cold_dok", {30'b0, m1_data_ok, m0_data_ok}, 32'h0);
        tick();
        m0_req = 1'b0;
        m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
`ifdef SRAM_ARB_RR_EN
        chk("cold_dok2", {30'b0, m1_data_ok, m0_data_ok}, 32'h1);
`else
        chk("cold_dok2", {30'b0, m1_data_ok, m0_data_ok}, 32'h2);
        chk("cold_rd",   m1_rdata, 32'hdeadbeef);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between two requesters of the MIPS core: the instruction-fetch path (m0, read-only) and the load/store path (m1, read/write).
- Lets a unified-memory or multicycle variant of the CPU run on a single SRAM macro.
- Uses a req/addr_ok/data_ok handshake on both masters, accepts at most one request per cycle, and routes each response back to its owner one cycle after acceptance.

Parameters:
- ADDR_W, 32, address width on both masters and the SRAM port.
- STARVE_LIMIT, 4, maximum consecutive m1 grants while m0 is waiting. 0 means m0 wins every conflict.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m0_req  in  1  fetch request
- m0_addr  in  ADDR_W  fetch byte address
- m0_addr_ok  out  1  m0 request accepted this cycle
- m0_data_ok  out  1  m0 read data valid this cycle
- m0_rdata  out  32  m0 read data
- m1_req  in  1  data request
- m1_wr  in  1  1 = write, 0 = read
- m1_wstrb  in  4  byte write enables
- m1_addr  in  ADDR_W  data byte address
- m1_wdata  in  32  write data
- m1_addr_ok  out  1  m1 request accepted
- m1_data_ok  out  1  m1 response; read data valid, or write completed
- m1_rdata  out  32  m1 read data
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address (SRAM indexes [11:2])
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after the access

Behaviour:
- Handshake:
  - A master holds req and all its request fields stable until it sees addr_ok.
  - addr_ok is combinational from the grant.
  - A request accepted in cycle N gets data_ok in cycle N+1. Latency is fixed at 1 and there are no wait states.
- Grant, per cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: m1 is granted, unless starve_cnt == STARVE_LIMIT, in which case m0 is granted.
  - Neither requesting: no grant.
- SRAM drive:
  - sram_en = m0_addr_ok | m1_addr_ok.
  - sram_addr / sram_wdata are muxed from the granted master.
  - sram_wen = m1_wstrb when m1 is granted with m1_wr = 1; otherwise 0.
  - When idle: sram_addr = 0, sram_wdata = 0, sram_wen = 0.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when m0_req = 1 and m1 is granted.
  - Clears when m0 is granted or m0_req = 0.
  - Never exceeds STARVE_LIMIT.
- Response tracking:
  - Registers resp_v and resp_id are loaded at every cycle edge with (any grant, granted id).
  - m0_data_ok = resp_v & (resp_id == 0).
  - m1_data_ok = resp_v & (resp_id == 1).
  - m0_rdata and m1_rdata are both wired to sram_rdata; each is only meaningful under its own data_ok.
- Back-to-back: a new request can be accepted in the same cycle a previous response is returned. Throughput is one access per cycle.
- A write issues data_ok exactly like a read. rdata during a write response is don't-care.
- Reset:
  - resp_v = 0, resp_id = 0, starve_cnt = 0.
  - While reset is high, all addr_ok, data_ok, sram_en and sram_wen outputs are 0.
  - A response pending when reset asserts is dropped and never returned.
- Two-state FSM per cycle (IDLE: resp_v = 0; RESP: resp_v = 1); transitions are determined solely by the grant.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: on conflict, strict round-robin. A last_gnt register (reset value 1, so m0 wins the first conflict) decides; the master not granted last wins. starve_cnt and STARVE_LIMIT are unused.
- Undefined: m1 priority with the starvation limit, as described above.

Decomposition:
- Package sram_arb_pkg holds:
  - Master id constants: ARB_ID_FETCH = 0, ARB_ID_DATA = 1.
  - Default STARVE_LIMIT.
  - The request-bundle typedef: addr, wr, wstrb, wdata.
- One sub-module, arb_pick:
  - Purely combinational 2-way grant logic.
  - Inputs: both reqs, the starve/last_gnt state.
  - Outputs: one-hot grant.
  - Keeps the policy macro confined to a single file.

Test Plan:
- Only m0_req = 1, m0_addr = 0xbfc00000:
  - m0_addr_ok same cycle, sram_addr = 0xbfc00000, sram_wen = 0.
  - m0_data_ok next cycle, m0_rdata = SRAM content.
  - m1_data_ok stays 0.
- m1 write, addr = 0x10, wdata = 0xdeadbeef, wstrb = 0xf, followed by m1 read of 0x10:
  - sram_wen = 0xf in cycle 0.
  - m1_data_ok in cycles 1 and 2.
  - m1_rdata = 0xdeadbeef in cycle 2.
- Both reqs held high for 12 cycles, STARVE_LIMIT = 4:
  - Grant sequence m1 ×4, m0, m1 ×4, m0, m1, m1.
  - Each data_ok goes to the correct master one cycle after its grant.
- Same stimulus with SRAM_ARB_RR_EN defined:
  - Grants alternate m0, m1, m0, …
- Reset asserted in the cycle after an m1 read is accepted:
  - No m1_data_ok, all outputs 0 during reset.
  - First post-reset grant behaves as from cold start.
- Partial write, wstrb = 0x3 to a word holding 0x11223344, wdata = 0xaaaabbbb:
  - Readback = 0x1122bbbb.
